// File: rtl/uart_rx_fifo_if.sv
// Receive FIFO bus: producer side (receiver byte + Done level, consumer
// ready, overrun clear) and the FIFO's FWFT output/status side.
interface uart_rx_fifo_if #(
  parameter int unsigned ADDR_W = 4
);
  logic [7:0]      rx_data;
  logic            rx_done;
  logic [7:0]      dout;
  logic            dout_valid;
  logic            dout_ready;
  logic [ADDR_W:0] count;
  logic            full;
  logic            overrun;
  logic            clr_overrun;

  modport master (
    output rx_data, rx_done, dout_ready, clr_overrun,
    input  dout, dout_valid, count, full, overrun
  );

  modport slave (
    input  rx_data, rx_done, dout_ready, clr_overrun,
    output dout, dout_valid, count, full, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver. Captures rx_data on the
// rising edge of rx_done, presents the head byte first-word-fall-through,
// and flags dropped bytes with a sticky overrun bit.
module uart_rx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input logic         clk,
  input logic         reset,
  uart_rx_fifo_if.slave bus
);
  localparam int unsigned CW = ADDR_W + 1;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CW-1:0]     count_q;
  logic              done_d;
  logic              overrun_q;

  logic push;
  logic pop;
  logic accept;
  logic drop;
  logic full_w;
  logic valid_w;

  // Handshake decode: edge-detected push, guarded pop, accept/drop split.
  // A push into a full FIFO is still accepted when a pop frees a slot.
  always_comb begin
    full_w  = (count_q == CW'(DEPTH));
    valid_w = (count_q != '0);
    push    = bus.rx_done & ~done_d;
    pop     = valid_w & bus.dout_ready;
    accept  = push & (~full_w | pop);
    drop    = push & full_w & ~pop;
  end

  // Output drive: FWFT head read combinationally, status from registers.
  always_comb begin
    bus.dout       = mem[rd_ptr];
    bus.dout_valid = valid_w;
    bus.full       = full_w;
    bus.count      = count_q;
    bus.overrun    = overrun_q;
  end

  // Control state: Done edge detector, pointers, occupancy, overrun flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_d    <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      done_d <= bus.rx_done;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop)                 overrun_q <= 1'b1;
      else if (bus.clr_overrun) overrun_q <= 1'b0;
    end
  end

  // Byte storage: no reset, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (!reset && accept) mem[wr_ptr] <= bus.rx_data;
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios followed by a randomized run,
// all checked against a queue-based model of the receive buffer.
module tb_uart_rx_fifo;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;

  logic clk = 1'b0;
  logic reset;

  uart_rx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: queue of stored bytes, previous Done level, overrun.
  byte unsigned q[$];
  bit           m_done_prev = 1'b1;
  bit           m_ovr       = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("count", 32'(bus.count), q.size());
    check("dout_valid", 32'(bus.dout_valid), (q.size() != 0) ? 1 : 0);
    check("full", 32'(bus.full), (q.size() == DEPTH) ? 1 : 0);
    check("overrun", 32'(bus.overrun), 32'(m_ovr));
    if (q.size() != 0) check("dout", 32'(bus.dout), 32'(q[0]));
  endtask

  // Advance the model by one clock using the inputs currently driven,
  // then let the DUT take the same edge and compare just after it.
  task automatic tick();
    bit do_push, do_pop, dropped;
    if (reset) begin
      q.delete();
      m_done_prev = 1'b1;
      m_ovr       = 1'b0;
    end else begin
      do_push = bus.rx_done && !m_done_prev;
      do_pop  = (q.size() != 0) && bus.dout_ready;
      dropped = 1'b0;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        if (q.size() < DEPTH) q.push_back(bus.rx_data);
        else dropped = 1'b1;
      end
      if (dropped)              m_ovr = 1'b1;
      else if (bus.clr_overrun) m_ovr = 1'b0;
      m_done_prev = bus.rx_done;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    tick();
    bus.rx_done = 1'b0;
    bus.rx_data = 8'hxx;
    tick();
  endtask

  task automatic drain_expect(input string tag, input logic [7:0] exp);
    check(tag, 32'(bus.dout), 32'(exp));
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    bus.rx_data     = 8'h00;
    bus.rx_done     = 1'b1;
    bus.dout_ready  = 1'b0;
    bus.clr_overrun = 1'b0;
    @(negedge clk);

    // Reset with Done already high: the held level must not be captured.
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("rst_count", 32'(bus.count), 0);
    check("rst_valid", 32'(bus.dout_valid), 0);
    bus.rx_done = 1'b0;
    tick();

    // Single byte in, one-cycle latency, then popped.
    send(8'hAB);
    check("ab_dout", 32'(bus.dout), 32'h000000AB);
    drain_expect("ab_pop", 8'hAB);
    check("ab_empty", 32'(bus.count), 0);

    // Done held high for 20 cycles gives exactly one push.
    bus.rx_data = 8'h55;
    bus.rx_done = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    bus.rx_done = 1'b0;
    tick();
    check("hold_count", 32'(bus.count), 1);
    check("hold_ovr", 32'(bus.overrun), 0);
    drain_expect("hold_pop", 8'h55);

    // Fill, overflow with 0xFF, drain in order.
    for (int i = 0; i < 16; i++) send(8'(i));
    check("fill_full", 32'(bus.full), 1);
    check("fill_count", 32'(bus.count), 16);
    send(8'hFF);
    check("drop_ovr", 32'(bus.overrun), 1);
    check("drop_count", 32'(bus.count), 16);
    for (int i = 0; i < 16; i++) drain_expect("drain_order", 8'(i));
    check("drain_empty", 32'(bus.dout_valid), 0);
    bus.clr_overrun = 1'b1;
    tick();
    bus.clr_overrun = 1'b0;

    // Push and pop together while full: accepted, count holds, no overrun.
    for (int i = 0; i < 16; i++) send(8'(i));
    bus.rx_data    = 8'hA5;
    bus.rx_done    = 1'b1;
    bus.dout_ready = 1'b1;
    tick();
    bus.rx_done    = 1'b0;
    bus.dout_ready = 1'b0;
    tick();
    check("pp_count", 32'(bus.count), 16);
    check("pp_ovr", 32'(bus.overrun), 0);
    for (int i = 1; i < 16; i++) drain_expect("wrap_order", 8'(i));
    drain_expect("wrap_last", 8'hA5);

    // Overrun clear racing a fresh drop: set wins; clear alone then works.
    for (int i = 0; i < 16; i++) send(8'(8'h80 + i));
    send(8'h11);
    check("race_pre", 32'(bus.overrun), 1);
    bus.rx_data     = 8'h22;
    bus.rx_done     = 1'b1;
    bus.clr_overrun = 1'b1;
    tick();
    bus.rx_done     = 1'b0;
    bus.clr_overrun = 1'b0;
    check("race_set_wins", 32'(bus.overrun), 1);
    bus.clr_overrun = 1'b1;
    tick();
    bus.clr_overrun = 1'b0;
    check("race_clear", 32'(bus.overrun), 0);
    bus.dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    bus.dout_ready = 1'b0;

    // Receiver-style byte stream, then reset with bytes queued.
    send(8'hAB);
    send(8'h3C);
    send(8'hF0);
    drain_expect("stream0", 8'hAB);
    drain_expect("stream1", 8'h3C);
    send(8'h77);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_reset", 32'(bus.count), 0);
    bus.rx_done = 1'b0;
    tick();

    // Randomized traffic with alternating consumer speed.
    for (int i = 0; i < 3000; i++) begin
      bus.rx_data     = 8'($urandom);
      bus.rx_done     = ($urandom_range(0, 2) != 0);
      bus.dout_ready  = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                             : ($urandom_range(0, 3) != 0);
      bus.clr_overrun = ($urandom_range(0, 19) == 0);
      reset           = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset           = 1'b0;
    bus.rx_done     = 1'b0;
    bus.dout_ready  = 1'b0;
    bus.clr_overrun = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
